udp_rx_dma_framer: RTL and testbench

Receive-side counterpart of the DMA→FIFO→UDP transmit path. Consumes payload bytes delivered by `adaptive_udp` on its `rec_*` port, buffers one whole datagram, then emits it on an AXI4-Stream master toward the DMA S2MM/FIFO in the same framing the transmit side consumes. That framing is a 2-byte little-endian length prefix, then the payload, with `tlast` on the final payload byte. Sits in the `dri_clk` domain between `adaptive_udp` and the receive AXIS FIFO.

---
 rtl/udp_rx_dma_framer_pkg.sv | 21 ++
 rtl/udp_rx_dma_framer_if.sv | 24 ++
 rtl/udp_rx_dma_framer_sdp_ram.sv | 23 ++
 rtl/udp_rx_dma_framer.sv | 166 ++++++++++++++++
 tb/tb_udp_rx_dma_framer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/udp_rx_dma_framer_pkg.sv
// Shared types for the UDP receive framer: FSM state encoding and length width.
// The length prefix is always 16 bits, whatever ADDR_W the buffer uses.
package udp_rx_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DROP,
        HDR_LO,
        HDR_HI,
        PAYLOAD
    } rx_state_t;

    // Selects one byte of the little-endian length prefix.
    function automatic logic [7:0] len_byte(input logic [LEN_W-1:0] len, input logic hi);
        return hi ? len[15:8] : len[7:0];
    endfunction

endpackage

// File: rtl/udp_rx_dma_framer_if.sv
// Byte-wide valid/ready stream with an end-of-frame marker.
// Used for both the adaptive_udp receive port and the AXIS output.
interface udp_rx_dma_framer_if;

    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );

endinterface

// File: rtl/udp_rx_dma_framer_sdp_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
// No reset on the storage or read register so it maps onto block RAM.
module sdp_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_rx_dma_framer.sv
// Buffers one received UDP datagram, then replays it as a length-prefixed byte stream.
// Oversize datagrams are swallowed and counted instead of forwarded.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for first byte, len = 0
// FILL    | storing bytes into RAM[len]
// DROP    | datagram exceeded MAX_LEN, discard until rec last
// HDR_LO  | presenting pkt_len[7:0]
// HDR_HI  | presenting pkt_len[15:8], RAM address 0 prefetched
// PAYLOAD | streaming RAM[rd_ptr], last on byte pkt_len-1
module udp_rx_dma_framer
    import udp_rx_pkg::*;
#(
    parameter int MAX_LEN = 2048,
    parameter int ADDR_W  = 11
) (
    input  logic                dri_clk,
    input  logic                rst,
    udp_rx_dma_framer_if.slave  rec,
    udp_rx_dma_framer_if.master m_axis,
    output logic [LEN_W-1:0]    pkt_cnt,
    output logic [LEN_W-1:0]    drop_cnt
);

    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    rx_state_t         state, state_nx;
    logic [CNT_W-1:0]  len, len_nx;
    logic [LEN_W-1:0]  pkt_len, pkt_len_nx;
    logic [LEN_W-1:0]  pkt_cnt_nx, drop_cnt_nx;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nx, rd_addr;
    logic              ram_we;
    logic [7:0]        rd_data;
    logic              rec_acc;
    logic              out_hs;
    logic              last_byte;
    logic              in_rx;
    logic              in_tx;

    assign in_rx = (state == IDLE) || (state == FILL) || (state == DROP);
    assign in_tx = (state == HDR_LO) || (state == HDR_HI) || (state == PAYLOAD);

    // Gated with rst so upstream sees no acceptance while reset is held.
    assign rec.ready    = !rst && in_rx;
    assign m_axis.valid = in_tx;
    assign last_byte    = (state == PAYLOAD) && (LEN_W'(rd_ptr) == pkt_len - LEN_W'(1));
    assign m_axis.last  = last_byte;

    assign rec_acc = rec.valid && rec.ready;
    assign out_hs  = m_axis.valid && m_axis.ready;

    always_comb begin
        m_axis.data = 8'h00;
        case (state)
            HDR_LO:  m_axis.data = len_byte(pkt_len, 1'b0);
            HDR_HI:  m_axis.data = len_byte(pkt_len, 1'b1);
            PAYLOAD: m_axis.data = rd_data;
            default: m_axis.data = 8'h00;
        endcase
    end

    sdp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (dri_clk),
        .we    (ram_we),
        .waddr (len[ADDR_W-1:0]),
        .wdata (rec.data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge dri_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            len      <= '0;
            pkt_len  <= '0;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            len      <= len_nx;
            pkt_len  <= pkt_len_nx;
            rd_ptr   <= rd_ptr_nx;
            pkt_cnt  <= pkt_cnt_nx;
            drop_cnt <= drop_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        len_nx      = len;
        pkt_len_nx  = pkt_len;
        rd_ptr_nx   = rd_ptr;
        pkt_cnt_nx  = pkt_cnt;
        drop_cnt_nx = drop_cnt;
        ram_we      = 1'b0;
        // Read address holds on stall so rd_data stays put; it runs one ahead on a handshake.
        rd_addr     = rd_ptr;

        case (state)
            IDLE, FILL: begin
                if (rec_acc) begin
                    ram_we = (len < MAX_CNT);
                    if (rec.last) begin
                        len_nx = '0;
                        if (len == MAX_CNT) begin
                            drop_cnt_nx = drop_cnt + LEN_W'(1);
                            state_nx    = IDLE;
                        end else begin
                            pkt_len_nx = LEN_W'(len) + LEN_W'(1);
                            rd_ptr_nx  = '0;
                            state_nx   = HDR_LO;
                        end
                    end else if (len == MAX_CNT) begin
                        len_nx   = '0;
                        state_nx = DROP;
                    end else begin
                        len_nx   = len + CNT_W'(1);
                        state_nx = FILL;
                    end
                end
            end

            DROP: begin
                if (rec_acc && rec.last) begin
                    drop_cnt_nx = drop_cnt + LEN_W'(1);
                    state_nx    = IDLE;
                end
            end

            HDR_LO: begin
                if (out_hs) begin
                    state_nx = HDR_HI;
                end
            end

            HDR_HI: begin
                if (out_hs) begin
                    state_nx = PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (out_hs) begin
                    if (last_byte) begin
                        pkt_cnt_nx = pkt_cnt + LEN_W'(1);
                        rd_ptr_nx  = '0;
                        state_nx   = IDLE;
                    end else begin
                        rd_ptr_nx = rd_ptr + ADDR_W'(1);
                        rd_addr   = rd_ptr + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_udp_rx_dma_framer.sv
// Directed bench for udp_rx_dma_framer: length prefix, payload order, stalls,
// oversize drop, full-size datagram with upstream back-pressure, and mid-drain reset.
module tb_udp_rx_dma_framer;

    logic        dri_clk = 1'b0;
    logic        rst;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int errors  = 0;

    udp_rx_dma_framer_if rec_bus ();
    udp_rx_dma_framer_if m_bus ();

    udp_rx_dma_framer #(
        .MAX_LEN (2048),
        .ADDR_W  (11)
    ) dut (
        .dri_clk  (dri_clk),
        .rst      (rst),
        .rec      (rec_bus),
        .m_axis   (m_bus),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 dri_clk = ~dri_clk;

    function automatic logic [7:0] pat(input int k, input logic [7:0] seed);
        return 8'(k * 7) + seed;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int len, input logic [7:0] seed);
        int vbad = 0;
        int rbad = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge dri_clk);
            if (m_bus.valid) vbad++;
            if (!rec_bus.ready) rbad++;
            rec_bus.valid = 1'b1;
            rec_bus.data  = pat(i, seed);
            rec_bus.last  = (i == len - 1);
        end
        chk("fill_no_valid", vbad, 0);
        chk("fill_ready", rbad, 0);
    endtask

    // Collects the output stream; stop_at < 0 means the whole frame.
    task automatic drain(input int len, input logic [7:0] seed, input bit rnd,
                         input int stop_at, input bit hold);
        int         idx = 0;
        int         cyc = 0;
        int         gaps = 0;
        int         stab_bad = 0;
        int         rbad = 0;
        int         target;
        logic       pv = 1'b0;
        logic       pr = 1'b0;
        logic       pl = 1'b0;
        logic [7:0] pd = 8'h00;
        logic [7:0] exp_d;
        target = (stop_at >= 0) ? stop_at : len + 2;
        while (idx < target && cyc < 40 * len + 200) begin
            @(negedge dri_clk);
            cyc++;
            if (!hold) begin
                rec_bus.valid = 1'b0;
            end else begin
                if (cyc == 1) rec_bus.data = 8'h3C;
                if (rec_bus.ready) rbad++;
            end
            if (cyc == 1) chk("first_valid", m_bus.valid, 1);
            m_bus.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr && (m_bus.valid !== 1'b1 || m_bus.data !== pd || m_bus.last !== pl))
                stab_bad++;
            if (!m_bus.valid) gaps++;
            if (m_bus.valid && m_bus.ready) begin
                exp_d = (idx == 0) ? 8'(len) : (idx == 1) ? 8'(len >> 8) : pat(idx - 2, seed);
                chk("byte", m_bus.data, exp_d);
                chk("last", m_bus.last, idx == len + 1);
                idx++;
            end
            pv = m_bus.valid;
            pr = m_bus.ready;
            pd = m_bus.data;
            pl = m_bus.last;
        end
        chk("drain_done", idx, target);
        chk("stall_stable", stab_bad, 0);
        if (!rnd) begin
            chk("gaps", gaps, 0);
            chk("cycles", cyc, target);
        end
        if (hold) chk("held_not_taken", rbad, 0);
    endtask

    task automatic post(input int exp_pkt, input int exp_drop);
        @(negedge dri_clk);
        chk("post_ready", rec_bus.ready, 1);
        chk("post_valid", m_bus.valid, 0);
        chk("pkt_cnt", pkt_cnt, exp_pkt);
        chk("drop_cnt", drop_cnt, exp_drop);
    endtask

    initial begin
        rst           = 1'b1;
        rec_bus.valid = 1'b0;
        rec_bus.data  = 8'h00;
        rec_bus.last  = 1'b0;
        m_bus.ready   = 1'b0;

        repeat (3) @(negedge dri_clk);
        chk("rst_ready", rec_bus.ready, 0);
        chk("rst_valid", m_bus.valid, 0);
        chk("rst_last", m_bus.last, 0);
        chk("rst_data", m_bus.data, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", rec_bus.ready, 1);

        // 65 bytes, continuous tready
        send(65, 8'h11);
        drain(65, 8'h11, 1'b0, -1, 1'b0);
        post(1, 0);

        // same datagram, random back-pressure
        send(65, 8'h11);
        drain(65, 8'h11, 1'b1, -1, 1'b0);
        post(2, 0);

        // single byte A5
        send(1, 8'hA5);
        drain(1, 8'hA5, 1'b0, -1, 1'b0);
        post(3, 0);

        // oversize datagram dropped, then a 10-byte one
        send(2049, 8'h33);
        @(negedge dri_clk);
        rec_bus.valid = 1'b0;
        chk("drop_no_valid", m_bus.valid, 0);
        chk("drop_cnt_upd", drop_cnt, 1);
        chk("drop_ready", rec_bus.ready, 1);
        send(10, 8'h5A);
        drain(10, 8'h5A, 1'b0, -1, 1'b0);
        post(4, 1);

        // exactly MAX_LEN with a byte held by upstream during drain
        send(2048, 8'h02);
        drain(2048, 8'h02, 1'b0, -1, 1'b1);
        post(5, 1);
        drain(1, 8'h3C, 1'b0, -1, 1'b0);
        post(6, 1);

        // reset after 3 payload bytes emitted
        send(65, 8'h77);
        drain(65, 8'h77, 1'b0, 5, 1'b0);
        @(negedge dri_clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", m_bus.valid, 0);
        chk("mid_rst_last", m_bus.last, 0);
        chk("mid_rst_data", m_bus.data, 0);
        chk("mid_rst_ready", rec_bus.ready, 0);
        chk("mid_rst_pkt", pkt_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        @(negedge dri_clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_release", rec_bus.ready, 1);
        send(4, 8'hC1);
        drain(4, 8'hC1, 1'b0, -1, 1'b0);
        post(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
